// File: rtl/onc_mc_if.sv
// Memory-side handshake bundles for the onc_mc core.
// onc_imem_if carries instruction fetches, onc_dmem_if carries loads and stores.
// In both, the core is the master and the memory system is the slave.

interface onc_imem_if #(
    parameter int AW = 16,
    parameter int IW = 16
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [IW-1:0] din;

    modport master (output req, output addr, input ack, input din);
    modport slave  (input req, input addr, output ack, output din);
endinterface

interface onc_dmem_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          ack;
    logic [DW-1:0] din;

    modport master (output req, output we, output addr, output dout, input ack, input din);
    modport slave  (input req, input we, input addr, input dout, output ack, output din);
endinterface

// File: rtl/onc_mc.sv
// onc_mc: multi-cycle ONC core with handshaked instruction/data memories.
// Instruction format: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb, [7:0] imm8.
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (these five update Z/C),
// 6 LDI rd=zext(imm8), 7 LDHI rd={imm8,rd.low}, 8 LD rd<-[ra], 9 ST [ra]<-rd,
// A BRA pc+=sext(imm8), B BZ, C BC, D JR pc=ra; E/F retire as NOP.
// Every architectural update happens on the single retire edge.

module onc_mc #(
    parameter int                DATA_W   = 16,
    parameter int                INST_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = {DATA_W{1'b0}},
    parameter int                CNT_W    = 32
) (
    input  logic             clock,
    input  logic             n_rst,
    onc_imem_if.master       imem,
    onc_dmem_if.master       dmem,
    input  logic             halt_req,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LDHI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BRA  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BC   = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;

    localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> (DATA_W - DATA_W / 2);

    state_t              state_r, state_nx_s;
    logic [DATA_W-1:0]   pc_r;
    logic [INST_W-1:0]   ir_r;
    logic [DATA_W-1:0]   regs_r [16];
    logic                flag_z_r, flag_c_r;
    logic                imem_req_r, dmem_req_r, dmem_we_r;
    logic [DATA_W-1:0]   dmem_addr_r, dmem_dout_r;
    logic                halted_r, retire_r;
    logic [CNT_W-1:0]    retire_cnt_r;

    logic [3:0]          op_s, rd_idx_s, ra_idx_s, rb_idx_s;
    logic [7:0]          imm8_s;
    logic [DATA_W-1:0]   rd_val_s, ra_val_s, rb_val_s, imm_z_s, imm_sx_s, pc_inc_s;
    logic [DATA_W-1:0]   alu_res_s, br_target_s;
    logic                carry_s, wr_en_s, flag_en_s, is_mem_s, br_taken_s, retire_now_s;

    assign op_s     = ir_r[15:12];
    assign rd_idx_s = ir_r[11:8];
    assign ra_idx_s = ir_r[7:4];
    assign rb_idx_s = ir_r[3:0];
    assign imm8_s   = ir_r[7:0];
    assign rd_val_s = regs_r[rd_idx_s];
    assign ra_val_s = regs_r[ra_idx_s];
    assign rb_val_s = regs_r[rb_idx_s];
    assign imm_z_s  = {{(DATA_W-8){1'b0}}, imm8_s};
    assign imm_sx_s = {{(DATA_W-8){imm8_s[7]}}, imm8_s};
    assign pc_inc_s = pc_r + DATA_W'(1);

    // Decode, ALU, extender and branch resolution for the instruction in IR.
    always_comb begin
        alu_res_s   = {DATA_W{1'b0}};
        carry_s     = 1'b0;
        wr_en_s     = 1'b0;
        flag_en_s   = 1'b0;
        is_mem_s    = 1'b0;
        br_taken_s  = 1'b0;
        br_target_s = pc_inc_s;
        case (op_s)
            OP_ADD: begin
                {carry_s, alu_res_s} = {1'b0, ra_val_s} + {1'b0, rb_val_s};
                wr_en_s   = 1'b1;
                flag_en_s = 1'b1;
            end
            OP_SUB: begin
                // carry reports a borrow on subtraction
                {carry_s, alu_res_s} = {1'b0, ra_val_s} - {1'b0, rb_val_s};
                wr_en_s   = 1'b1;
                flag_en_s = 1'b1;
            end
            OP_AND: begin
                alu_res_s = ra_val_s & rb_val_s;
                wr_en_s   = 1'b1;
                flag_en_s = 1'b1;
            end
            OP_OR: begin
                alu_res_s = ra_val_s | rb_val_s;
                wr_en_s   = 1'b1;
                flag_en_s = 1'b1;
            end
            OP_XOR: begin
                alu_res_s = ra_val_s ^ rb_val_s;
                wr_en_s   = 1'b1;
                flag_en_s = 1'b1;
            end
            OP_LDI: begin
                alu_res_s = imm_z_s;
                wr_en_s   = 1'b1;
            end
            OP_LDHI: begin
                alu_res_s = (imm_z_s << (DATA_W / 2)) | (rd_val_s & LO_MASK);
                wr_en_s   = 1'b1;
            end
            OP_LD: begin
                // only committed from S_MEM, where dmem.din is the returned word
                alu_res_s = dmem.din;
                wr_en_s   = 1'b1;
                is_mem_s  = 1'b1;
            end
            OP_ST: begin
                is_mem_s = 1'b1;
            end
            OP_BRA: begin
                br_taken_s  = 1'b1;
                br_target_s = pc_r + imm_sx_s;
            end
            OP_BZ: begin
                br_taken_s  = flag_z_r;
                br_target_s = pc_r + imm_sx_s;
            end
            OP_BC: begin
                br_taken_s  = flag_c_r;
                br_target_s = pc_r + imm_sx_s;
            end
            OP_JR: begin
                br_taken_s  = 1'b1;
                br_target_s = ra_val_s;
            end
            default: begin
                // NOP and undefined opcodes: nothing written, PC+1
                br_taken_s = 1'b0;
            end
        endcase
    end

    assign retire_now_s = ((state_r == S_EXEC) && !is_mem_s) ||
                          ((state_r == S_MEM) && dmem_req_r && dmem.ack);

    // Next-state selection; acks only count while the matching request is up.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (imem_req_r && imem.ack) state_nx_s = S_EXEC;
                else                        state_nx_s = S_FETCH;
            end
            S_EXEC: begin
                if (is_mem_s)      state_nx_s = S_MEM;
                else if (halt_req) state_nx_s = S_HALT;
                else               state_nx_s = S_FETCH;
            end
            S_MEM: begin
                if (dmem_req_r && dmem.ack) state_nx_s = halt_req ? S_HALT : S_FETCH;
                else                        state_nx_s = S_MEM;
            end
            S_HALT: begin
                if (halt_req) state_nx_s = S_HALT;
                else          state_nx_s = S_FETCH;
            end
            default: state_nx_s = S_FETCH;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= S_FETCH;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            halted_r     <= 1'b0;
            retire_r     <= 1'b0;
            retire_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            imem_req_r <= (state_nx_s == S_FETCH);
            dmem_req_r <= (state_nx_s == S_MEM);
            halted_r   <= (state_nx_s == S_HALT);
            retire_r   <= retire_now_s;
            if (retire_now_s) retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        end
    end

    // Architectural state: IR on fetch ack, PC/regs/flags on retire only.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pc_r     <= RESET_PC;
            ir_r     <= {INST_W{1'b0}};
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            for (int i = 0; i < 16; i++) regs_r[i] <= {DATA_W{1'b0}};
        end else begin
            if ((state_r == S_FETCH) && imem_req_r && imem.ack) ir_r <= imem.din;
            if (retire_now_s) begin
                pc_r <= br_taken_s ? br_target_s : pc_inc_s;
                if (wr_en_s) regs_r[rd_idx_s] <= alu_res_s;
                if (flag_en_s) begin
                    flag_z_r <= (alu_res_s == {DATA_W{1'b0}});
                    flag_c_r <= carry_s;
                end
            end
        end
    end

    // Data-access address/data/direction, captured in EXEC and held through MEM.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            dmem_we_r   <= 1'b0;
            dmem_addr_r <= {DATA_W{1'b0}};
            dmem_dout_r <= {DATA_W{1'b0}};
        end else if ((state_r == S_EXEC) && is_mem_s) begin
            dmem_we_r   <= (op_s == OP_ST);
            dmem_addr_r <= ra_val_s;
            dmem_dout_r <= rd_val_s;
        end else if (retire_now_s) begin
            dmem_we_r <= 1'b0;
        end
    end

    assign imem.req   = imem_req_r;
    assign imem.addr  = pc_r;
    assign dmem.req   = dmem_req_r;
    assign dmem.we    = dmem_we_r;
    assign dmem.addr  = dmem_addr_r;
    assign dmem.dout  = dmem_dout_r;
    assign halted     = halted_r;
    assign retire     = retire_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_onc_mc.sv
// Directed bench for onc_mc: a table of instructions with hand-computed
// fetch addresses and store traffic, followed by halt and reset sequences.

module tb_onc_mc;

    logic        clock = 1'b0;
    logic        n_rst;
    logic        halt_req;
    logic        halted;
    logic        retire;
    logic [31:0] retire_cnt;

    onc_imem_if #(.AW(16), .IW(16)) imem ();
    onc_dmem_if #(.AW(16), .DW(16)) dmem ();

    onc_mc dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .imem       (imem),
        .dmem       (dmem),
        .halt_req   (halt_req),
        .halted     (halted),
        .retire     (retire),
        .retire_cnt (retire_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] exp_pc;
        int          iwait;
        logic        mem;
        logic        we;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        chk_dout;
        int          dwait;
        logic [15:0] ddin;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ireq();
        int n = 0;
        while (imem.req !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("fetch_req_seen", {31'd0, imem.req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [15:0] inst, input int iwait, input logic [15:0] exp_pc);
        wait_ireq();
        chk("fetch_addr", {16'd0, imem.addr}, {16'd0, exp_pc});
        for (int w = 0; w < iwait; w++) begin
            @(negedge clock);
            chk("fetch_hold_req", {31'd0, imem.req}, 32'd1);
            chk("fetch_hold_addr", {16'd0, imem.addr}, {16'd0, exp_pc});
        end
        imem.ack = 1'b1;
        imem.din = inst;
        @(negedge clock);
        imem.ack = 1'b0;
        imem.din = 16'hDEAD;
        chk("exec_ireq_low", {31'd0, imem.req}, 32'd0);
        chk("exec_no_retire", {31'd0, retire}, 32'd0);
    endtask

    task automatic do_mem(input logic we, input logic [15:0] addr, input logic [15:0] dout,
                          input logic chk_dout, input int dwait, input logic [15:0] ddin);
        @(negedge clock);
        for (int w = 0; w <= dwait; w++) begin
            chk("mem_req", {31'd0, dmem.req}, 32'd1);
            chk("mem_we", {31'd0, dmem.we}, {31'd0, we});
            chk("mem_addr", {16'd0, dmem.addr}, {16'd0, addr});
            if (chk_dout) chk("mem_dout", {16'd0, dmem.dout}, {16'd0, dout});
            chk("mem_ireq_low", {31'd0, imem.req}, 32'd0);
            if (w < dwait) @(negedge clock);
        end
        dmem.ack = 1'b1;
        dmem.din = ddin;
        @(negedge clock);
        dmem.ack = 1'b0;
        dmem.din = 16'h0000;
    endtask

    task automatic do_retire(input logic exp_halted);
        chk("retire_pulse", {31'd0, retire}, 32'd1);
        exp_cnt = exp_cnt + 32'd1;
        chk("retire_cnt", retire_cnt, exp_cnt);
        chk("halted", {31'd0, halted}, {31'd0, exp_halted});
        chk("dmem_req_after", {31'd0, dmem.req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst    = 1'b0;
        halt_req = 1'b0;
        imem.ack = 1'b0;
        imem.din = 16'h0000;
        dmem.ack = 1'b0;
        dmem.din = 16'h0000;

        //            inst      pc        iw  mem   we    addr      dout      chkd  dw  ddin
        vecs[0]  = '{16'h6105, 16'h0000, 3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // LDI r1,5
        vecs[1]  = '{16'h6310, 16'h0001, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // LDI r3,0x10
        vecs[2]  = '{16'h9130, 16'h0002, 0, 1'b1, 1'b1, 16'h0010, 16'h0005, 1'b1, 2, 16'h0000}; // ST r1->[r3]
        vecs[3]  = '{16'h8230, 16'h0003, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 0, 16'hBEEF}; // LD r2<-[r3]
        vecs[4]  = '{16'h9230, 16'h0004, 1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 0, 16'h0000}; // ST r2
        vecs[5]  = '{16'h1412, 16'h0005, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // ADD r4=r1+r2
        vecs[6]  = '{16'h9410, 16'h0006, 0, 1'b1, 1'b1, 16'h0005, 16'hBEF4, 1'b1, 1, 16'h0000}; // ST r4->[r1]
        vecs[7]  = '{16'h2511, 16'h0007, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // SUB r5=0, Z=1
        vecs[8]  = '{16'hB003, 16'h0008, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // BZ +3 taken
        vecs[9]  = '{16'h5642, 16'h000B, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // XOR r6=0x1B
        vecs[10] = '{16'hB005, 16'h000C, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // BZ not taken
        vecs[11] = '{16'h9630, 16'h000D, 0, 1'b1, 1'b1, 16'h0010, 16'h001B, 1'b1, 0, 16'h0000}; // ST r6
        vecs[12] = '{16'hE123, 16'h000E, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // undefined
        vecs[13] = '{16'h67FE, 16'h000F, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // LDI r7,0xFE
        vecs[14] = '{16'h77FF, 16'h0010, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // LDHI r7 -> FFFE
        vecs[15] = '{16'hD070, 16'h0011, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // JR r7
        vecs[16] = '{16'hA001, 16'hFFFE, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // BRA +1
        vecs[17] = '{16'h0000, 16'hFFFF, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // NOP, wraps
        vecs[18] = '{16'h9710, 16'h0000, 0, 1'b1, 1'b1, 16'h0005, 16'hFFFE, 1'b1, 0, 16'h0000}; // ST r7->[r1]
        vecs[19] = '{16'h1877, 16'h0001, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // ADD r8, C=1
        vecs[20] = '{16'hC004, 16'h0002, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // BC +4 taken
        vecs[21] = '{16'h4913, 16'h0006, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // OR r9=0x15
        vecs[22] = '{16'h3A91, 16'h0007, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000}; // AND r10=5
        vecs[23] = '{16'h9A90, 16'h0008, 0, 1'b1, 1'b1, 16'h0015, 16'h0005, 1'b1, 0, 16'h0000}; // ST r10->[r9]
        vecs[24] = '{16'h9830, 16'h0009, 0, 1'b1, 1'b1, 16'h0010, 16'hFFFC, 1'b1, 0, 16'h0000}; // ST r8->[r3]

        // reset held for three cycles
        repeat (3) begin
            @(negedge clock);
            chk("rst_ireq", {31'd0, imem.req}, 32'd0);
            chk("rst_iaddr", {16'd0, imem.addr}, 32'd0);
        end
        chk("rst_dreq", {31'd0, dmem.req}, 32'd0);
        chk("rst_dwe", {31'd0, dmem.we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        n_rst = 1'b1;
        @(negedge clock);
        chk("ireq_after_rst", {31'd0, imem.req}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            do_fetch(vecs[i].inst, vecs[i].iwait, vecs[i].exp_pc);
            if (vecs[i].mem)
                do_mem(vecs[i].we, vecs[i].addr, vecs[i].dout, vecs[i].chk_dout,
                       vecs[i].dwait, vecs[i].ddin);
            else
                @(negedge clock);
            do_retire(1'b0);
        end

        // halt requested while a store waits in S_MEM
        do_fetch(16'h9130, 0, 16'h000A);
        @(negedge clock);
        halt_req = 1'b1;
        chk("halt_mem_req", {31'd0, dmem.req}, 32'd1);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        @(negedge clock);
        chk("halt_not_yet2", {31'd0, halted}, 32'd0);
        dmem.ack = 1'b1;
        @(negedge clock);
        dmem.ack = 1'b0;
        do_retire(1'b1);
        chk("halt_ireq", {31'd0, imem.req}, 32'd0);
        repeat (3) begin
            imem.ack = 1'b1;
            dmem.ack = 1'b1;
            @(negedge clock);
            chk("halt_hold", {31'd0, halted}, 32'd1);
            chk("halt_no_ireq", {31'd0, imem.req}, 32'd0);
            chk("halt_no_dreq", {31'd0, dmem.req}, 32'd0);
            chk("halt_no_retire", {31'd0, retire}, 32'd0);
        end
        imem.ack = 1'b0;
        dmem.ack = 1'b0;
        halt_req = 1'b0;
        @(negedge clock);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_ireq", {31'd0, imem.req}, 32'd1);
        chk("resume_addr", {16'd0, imem.addr}, 32'h0000_000B);
        chk("resume_cnt", retire_cnt, exp_cnt);

        // reset asserted while a fetch is stalled
        repeat (2) @(negedge clock);
        n_rst = 1'b0;
        #1;
        chk("async_rst_ireq", {31'd0, imem.req}, 32'd0);
        chk("async_rst_pc", {16'd0, imem.addr}, 32'd0);
        chk("async_rst_cnt", retire_cnt, 32'd0);
        exp_cnt = 32'd0;
        @(negedge clock);
        n_rst = 1'b1;
        @(negedge clock);
        do_fetch(16'h6105, 0, 16'h0000);
        @(negedge clock);
        do_retire(1'b0);
        // registers are cleared: r0 address, r1 freshly loaded
        do_fetch(16'h9100, 0, 16'h0001);
        do_mem(1'b1, 16'h0000, 16'h0005, 1'b1, 0, 16'h0000);
        do_retire(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
